// File: rtl/consumer_txn_issuer.sv
// consumer_txn_issuer: turns queue read commands into tagged memory reads and reorders responses
module consumer_txn_issuer #(
   parameter int ADDR_WIDTH      = 64,
   parameter int ID_WIDTH        = 4,
   parameter int DATA_WIDTH      = 64,
   parameter int ELEM_BYTES_LOG2 = 3,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [4:0]            cfg_len_log2,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [31:0]           cmd_index,
   input  logic [15:0]           cmd_count,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [ADDR_WIDTH-1:0] req_addr,
   output logic [ID_WIDTH-1:0]   req_id,
   input  logic                  resp_valid,
   input  logic [ID_WIDTH-1:0]   resp_id,
   input  logic [DATA_WIDTH-1:0] resp_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  err_bad_id
);
   localparam int PW = $clog2(MAX_OUTSTANDING);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  base_q, base_d, req_addr_q, req_addr_d;
   logic [4:0]             len_q, len_d;
   logic [31:0]            idx_q, idx_d;
   logic [15:0]            cnt_q, cnt_d, k_q, k_d, ret_q, ret_d;
   logic [PW-1:0]          iptr_q, iptr_d, rptr_q, rptr_d, resp_slot;
   logic [MAX_OUTSTANDING-1:0] pend_q, pend_d, vld_q, vld_d;
   logic [DATA_WIDTH-1:0]  data_q [MAX_OUTSTANDING];
   logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic [ID_WIDTH-1:0]    req_id_q, req_id_d;
   logic cmd_ready_q, cmd_ready_d, req_valid_q, req_valid_d, out_valid_q, out_valid_d;
   logic out_last_q, out_last_d, busy_q, busy_d, err_q, err_d;
   logic req_hs, out_hs, resp_hit, resp_wr;

   function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [ADDR_WIDTH-1:0] b,
      input logic [4:0] l, input logic [31:0] i, input logic [15:0] k);
      logic [ADDR_WIDTH-1:0] m;
      m = (ADDR_WIDTH'(1) << l) - ADDR_WIDTH'(1);
      return b + (((ADDR_WIDTH'(i) + ADDR_WIDTH'(k)) & m) << ELEM_BYTES_LOG2);
   endfunction

   assign cmd_ready  = cmd_ready_q;
   assign req_valid  = req_valid_q;
   assign req_addr   = req_addr_q;
   assign req_id     = req_id_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign busy       = busy_q;
   assign err_bad_id = err_q;

   // Next state: command accept, request issue, response capture and in-order retire
   always_comb begin
      resp_slot = resp_id[PW-1:0];
      resp_hit  = ((resp_id >> PW) == '0) && pend_q[resp_slot];
      resp_wr   = resp_valid && resp_hit;
      req_hs    = req_valid_q && req_ready;
      out_hs    = out_valid_q && out_ready;
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      ret_d     = ret_q;
      iptr_d    = iptr_q;
      rptr_d    = rptr_q;
      pend_d    = pend_q;
      vld_d     = vld_q;
      if (state_q == IDLE && cmd_valid && cmd_count != '0) begin
         state_d = ISSUE;
         base_d  = cfg_base_addr;
         len_d   = cfg_len_log2;
         idx_d   = cmd_index;
         cnt_d   = cmd_count;
         k_d     = '0;
         ret_d   = '0;
      end
      if (req_hs) begin
         pend_d[iptr_q] = 1'b1;
         iptr_d         = iptr_q + PW'(1);
         k_d            = k_q + 16'd1;
         state_d        = (k_q + 16'd1 == cnt_q) ? DRAIN : state_d;
      end
      if (resp_wr) begin
         pend_d[resp_slot] = 1'b0;
         vld_d[resp_slot]  = 1'b1;
      end
      if (out_hs) begin
         vld_d[rptr_q] = 1'b0;
         rptr_d        = rptr_q + PW'(1);
         ret_d         = ret_q + 16'd1;
         state_d       = (ret_q + 16'd1 == cnt_q) ? IDLE : state_d;
      end
      req_valid_d = (state_d == ISSUE) && !pend_d[iptr_d] && !vld_d[iptr_d];
      req_addr_d  = elem_addr(base_d, len_d, idx_d, k_d);
      req_id_d    = ID_WIDTH'(iptr_d);
      out_valid_d = vld_d[rptr_d];
      out_data_d  = !out_valid_d ? out_data_q :
                    (resp_wr && resp_slot == rptr_d) ? resp_data : data_q[rptr_d];
      out_last_d  = out_valid_d && (ret_d + 16'd1 == cnt_d);
      err_d       = err_q || (resp_valid && !resp_hit);
      cmd_ready_d = state_d == IDLE;
      busy_d      = state_d != IDLE;
   end

   // Reorder buffer data storage; slot validity is tracked separately so no reset is needed
   always_ff @(posedge clk) begin
      if (resp_wr) data_q[resp_slot] <= resp_data;
   end

   // State and registered outputs, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         k_q         <= '0;
         ret_q       <= '0;
         iptr_q      <= '0;
         rptr_q      <= '0;
         pend_q      <= '0;
         vld_q       <= '0;
         cmd_ready_q <= 1'b1;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         req_id_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         ret_q       <= ret_d;
         iptr_q      <= iptr_d;
         rptr_q      <= rptr_d;
         pend_q      <= pend_d;
         vld_q       <= vld_d;
         cmd_ready_q <= cmd_ready_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         req_id_q    <= req_id_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end
endmodule

// File: tb/tb_consumer_txn_issuer.sv
// tb_consumer_txn_issuer: scoreboard bench for the consumer transaction issuer
module tb_consumer_txn_issuer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] cfg_base_addr;
   logic [4:0]  cfg_len_log2;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_index;
   logic [15:0] cmd_count;
   logic        req_valid, req_ready;
   logic [63:0] req_addr;
   logic [3:0]  req_id;
   logic        resp_valid;
   logic [3:0]  resp_id;
   logic [63:0] resp_data;
   logic        out_valid, out_ready, out_last, busy, err_bad_id;
   logic [63:0] out_data;

   typedef struct {logic [63:0] addr; logic [3:0] id;} req_t;
   typedef struct {logic [63:0] data; logic last;} out_t;
   req_t        exp_req [$];
   out_t        exp_out [$];
   logic [3:0]  cur_id [32];
   logic [63:0] cur_dat [32];
   logic [3:0]  m_iptr;
   int          checks = 0, errors = 0, req_seen = 0, s;
   logic        req_pend = 1'b0, out_pend = 1'b0;

   consumer_txn_issuer dut (
      .clk(clk), .rst_n(rst_n), .cfg_base_addr(cfg_base_addr), .cfg_len_log2(cfg_len_log2),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index), .cmd_count(cmd_count),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_id(req_id),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .err_bad_id(err_bad_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every visible request/element is compared with the queue front
   always @(negedge clk) begin
      if (rst_n) begin
         if (req_valid) begin
            if (exp_req.size() == 0) check("req_extra", 64'(req_valid), 64'd0);
            else begin
               check("req_addr", req_addr, exp_req[0].addr);
               check("req_id", 64'(req_id), 64'(exp_req[0].id));
               if (req_ready) begin
                  void'(exp_req.pop_front());
                  req_seen++;
               end
            end
         end else if (req_pend) check("req_drop", 64'(req_valid), 64'd1);
         req_pend = req_valid && !req_ready;
         if (out_valid) begin
            if (exp_out.size() == 0) check("out_extra", 64'(out_valid), 64'd0);
            else begin
               check("out_data", out_data, exp_out[0].data);
               check("out_last", 64'(out_last), 64'(exp_out[0].last));
               if (out_ready) void'(exp_out.pop_front());
            end
         end else if (out_pend) check("out_drop", 64'(out_valid), 64'd1);
         out_pend = out_valid && !out_ready;
      end
   end

   task automatic do_cmd(input logic [63:0] base, input logic [4:0] len,
                         input logic [31:0] idx, input logic [15:0] cnt);
      logic [63:0] mask;
      mask = (64'd1 << len) - 64'd1;
      for (int i = 0; i < 300 && !cmd_ready; i++) tick();
      check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
      cmd_valid     = 1'b1;
      cfg_base_addr = base;
      cfg_len_log2  = len;
      cmd_index     = idx;
      cmd_count     = cnt;
      for (int k = 0; k < int'(cnt); k++) begin
         cur_id[k]  = m_iptr + 4'(k);
         cur_dat[k] = {$urandom(), $urandom()};
         exp_req.push_back('{base + (((64'(idx) + 64'(k)) & mask) << 3), cur_id[k]});
         exp_out.push_back('{cur_dat[k], k == int'(cnt) - 1});
      end
      m_iptr = m_iptr + cnt[3:0];
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic send_resp(input logic [3:0] id, input logic [63:0] d);
      resp_valid = 1'b1;
      resp_id    = id;
      resp_data  = d;
      tick();
      resp_valid = 1'b0;
   endtask

   task automatic wait_reqs(input int n);
      for (int i = 0; i < 300 && req_seen < n; i++) @(negedge clk);
      check("req_wait", 64'(req_seen >= n), 64'd1);
      tick();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300 && !(cmd_ready && exp_out.size() == 0); i++) @(negedge clk);
      check("idle_ready", 64'(cmd_ready), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_drain", 64'(exp_out.size()), 64'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cfg_base_addr = '0; cfg_len_log2 = '0;
      cmd_index = '0; cmd_count = '0; req_ready = 1'b1; resp_valid = 1'b0;
      resp_id = '0; resp_data = '0; out_ready = 1'b1; m_iptr = '0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_req_valid", 64'(req_valid), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err_bad_id), 64'd0);
      check("rst_req_addr", req_addr, 64'd0);
      check("rst_req_id", 64'(req_id), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      // in-order responses, ids 0..2 from reset
      do_cmd(64'h1000, 5'd4, 32'd2, 16'd3);
      wait_reqs(3);
      for (int k = 0; k < 3; k++) send_resp(cur_id[k], cur_dat[k]);
      wait_idle();
      // index wrap at queue end with request backpressure
      req_ready = 1'b0;
      do_cmd(64'h2000, 5'd4, 32'd14, 16'd4);
      for (int i = 0; i < 10; i++) begin
         req_ready = i[0];
         tick();
      end
      req_ready = 1'b1;
      wait_reqs(7);
      for (int k = 0; k < 4; k++) send_resp(cur_id[k], cur_dat[k]);
      wait_idle();
      // out-of-order responses with output backpressure
      out_ready = 1'b0;
      do_cmd(64'h3000, 5'd3, 32'd5, 16'd3);
      wait_reqs(10);
      send_resp(cur_id[2], cur_dat[2]);
      send_resp(cur_id[0], cur_dat[0]);
      send_resp(cur_id[1], cur_dat[1]);
      repeat (3) tick();
      out_ready = 1'b1;
      wait_idle();
      // full reorder buffer, then one retire frees one issue slot
      s = req_seen;
      do_cmd(64'h4000, 5'd5, 32'd30, 16'd20);
      wait_reqs(s + 16);
      repeat (3) tick();
      @(negedge clk);
      check("full_req_valid", 64'(req_valid), 64'd0);
      check("full_count", 64'(req_seen), 64'(s + 16));
      tick();
      send_resp(cur_id[0], cur_dat[0]);
      @(negedge clk);
      check("retire_out_valid", 64'(out_valid), 64'd1);
      check("retire_req_valid", 64'(req_valid), 64'd0);
      @(negedge clk);
      check("reissue_req_valid", 64'(req_valid), 64'd1);
      tick();
      for (int k = 1; k < 20; k++) begin
         wait_reqs(s + k + 1);
         send_resp(cur_id[k], cur_dat[k]);
      end
      wait_idle();
      check("exp_req_empty", 64'(exp_req.size()), 64'd0);
      // stray response while idle
      check("err_before", 64'(err_bad_id), 64'd0);
      send_resp(4'd5, 64'hBAD0);
      @(negedge clk);
      check("err_set", 64'(err_bad_id), 64'd1);
      check("err_no_out", 64'(out_valid), 64'd0);
      repeat (3) tick();
      @(negedge clk);
      check("err_sticky", 64'(err_bad_id), 64'd1);
      tick();
      // zero-count command is accepted and ignored
      do_cmd(64'h5000, 5'd4, 32'd0, 16'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("zero_cmd_ready", 64'(cmd_ready), 64'd1);
         check("zero_busy", 64'(busy), 64'd0);
         check("zero_req_valid", 64'(req_valid), 64'd0);
      end
      tick();
      // asynchronous reset in the middle of ISSUE
      req_ready = 1'b0;
      do_cmd(64'h6000, 5'd4, 32'd3, 16'd8);
      repeat (2) tick();
      @(negedge clk);
      check("mid_busy", 64'(busy), 64'd1);
      check("mid_req_valid", 64'(req_valid), 64'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("arst_req_valid", 64'(req_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_err", 64'(err_bad_id), 64'd0);
      check("arst_req_addr", req_addr, 64'd0);
      check("arst_req_id", 64'(req_id), 64'd0);
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_out_data", out_data, 64'd0);
      exp_req.delete();
      exp_out.delete();
      m_iptr = '0;
      req_pend = 1'b0;
      out_pend = 1'b0;
      req_ready = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      // late response after reset targets a free slot
      send_resp(4'd3, 64'h1234);
      @(negedge clk);
      check("late_err", 64'(err_bad_id), 64'd1);
      check("late_no_out", 64'(out_valid), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
